// File: rtl/tx_frame_sequencer_if.sv
// Upstream symbol handshake between the symbol source and tx_frame_sequencer.
//   sym_in_i/q : 2-bit I/Q symbol offered by the source
//   sym_valid  : source has a symbol on sym_in_i/q
//   sym_ready  : sequencer takes the symbol this cycle (transfer = valid && ready)
interface tx_frame_sequencer_if;
  logic [1:0] sym_in_i;
  logic [1:0] sym_in_q;
  logic       sym_valid;
  logic       sym_ready;

  modport master (output sym_in_i, output sym_in_q, output sym_valid, input  sym_ready);
  modport slave  (input  sym_in_i, input  sym_in_q, input  sym_valid, output sym_ready);
endinterface

// File: rtl/tx_frame_sequencer.sv
// Timing and framing controller for the I/Q transmitter path.
// Free-running sample/symbol strobes plus a per-symbol frame sequencer:
// preamble -> counted payload from the upstream source -> idle flush.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : single-cycle frame request / frame cut-short request
//   up_if (slave)       : upstream symbol handshake (sym_in_i/q, sym_valid, sym_ready)
//   sam_clk_ena         : sample strobe (combinational from counters)
//   sym_clk_ena         : symbol strobe, always coincident with a sample strobe
//   syms_out_i/q        : registered 2-bit symbols to the transmitter filters
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
//   underrun_cnt        : saturating count of payload slots with sym_valid low
module tx_frame_sequencer #(
  parameter int unsigned SAM_DIV     = 4,
  parameter int unsigned SYM_PER_SAM = 4,
  parameter int unsigned PRE_LEN     = 8,
  parameter int unsigned PAY_LEN     = 32,
  parameter int unsigned FLUSH_LEN   = 12,
  parameter logic [1:0]  IDLE_SYM    = 2'b01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  tx_frame_sequencer_if.slave   up_if,
  output logic                  sam_clk_ena,
  output logic                  sym_clk_ena,
  output logic [1:0]            syms_out_i,
  output logic [1:0]            syms_out_q,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            underrun_cnt
);

  localparam int unsigned CLK_W   = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
  localparam int unsigned SAM_W   = (SYM_PER_SAM > 1) ? $clog2(SYM_PER_SAM) : 1;
  localparam int unsigned MAX_LEN = (PRE_LEN > PAY_LEN)
                                    ? ((PRE_LEN > FLUSH_LEN) ? PRE_LEN : FLUSH_LEN)
                                    : ((PAY_LEN > FLUSH_LEN) ? PAY_LEN : FLUSH_LEN);
  localparam int unsigned CNT_W   = $clog2(MAX_LEN);

  localparam logic [CLK_W-1:0] CLK_LAST   = CLK_W'(SAM_DIV - 1);
  localparam logic [SAM_W-1:0] SAM_LAST   = SAM_W'(SYM_PER_SAM - 1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST   = CNT_W'(PAY_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_PAY, ST_FLUSH} state_e;

  logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [SAM_W-1:0] sam_cnt_q, sam_cnt_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_pend_q, start_pend_d;
  logic             abort_pend_q, abort_pend_d;
  logic [1:0]       sym_i_q, sym_i_d;
  logic [1:0]       sym_q_q, sym_q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       underrun_q, underrun_d;

  // Strobes and ready are decoded straight from the counters/state.
  assign sam_clk_ena     = (clk_cnt_q == CLK_LAST);
  assign sym_clk_ena     = sam_clk_ena && (sam_cnt_q == SAM_LAST);
  assign up_if.sym_ready = (state_q == ST_PAY) && sym_clk_ena && !abort_pend_q;

  assign syms_out_i   = sym_i_q;
  assign syms_out_q   = sym_q_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign underrun_cnt = underrun_q;

  // Next-state: strobe counters, request flags, and the per-slot sequencer.
  always_comb begin
    clk_cnt_d    = clk_cnt_q;
    sam_cnt_d    = sam_cnt_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_pend_d = start_pend_q;
    abort_pend_d = abort_pend_q;
    sym_i_d      = sym_i_q;
    sym_q_d      = sym_q_q;
    underrun_d   = underrun_q;
    done_d       = 1'b0;

    clk_cnt_d = sam_clk_ena ? '0 : clk_cnt_q + CLK_W'(1);
    if (sam_clk_ena) begin
      sam_cnt_d = sym_clk_ena ? '0 : sam_cnt_q + SAM_W'(1);
    end

    // A start that coincides with abort is dropped.
    if ((state_q == ST_IDLE) && start && !abort) begin
      start_pend_d = 1'b1;
    end
    if (((state_q == ST_PRE) || (state_q == ST_PAY)) && abort) begin
      abort_pend_d = 1'b1;
    end
    if (state_q == ST_FLUSH) begin
      abort_pend_d = 1'b0;
    end

    if (sym_clk_ena) begin
      sym_i_d = IDLE_SYM;
      sym_q_d = IDLE_SYM;
      unique case (state_q)
        ST_IDLE: begin
          if (start_pend_q) begin
            sym_i_d      = 2'b11;
            sym_q_d      = 2'b11;
            state_d      = ST_PRE;
            cnt_d        = CNT_W'(1);
            start_pend_d = 1'b0;
          end
        end
        ST_PRE, ST_PAY: begin
          if (abort_pend_q) begin
            state_d      = ST_FLUSH;
            cnt_d        = CNT_W'(1);
            abort_pend_d = 1'b0;
          end else if (state_q == ST_PRE) begin
            // Preamble alternates 11/00 starting with 11 at index 0.
            sym_i_d = cnt_q[0] ? 2'b00 : 2'b11;
            sym_q_d = cnt_q[0] ? 2'b00 : 2'b11;
            if (cnt_q == PRE_LAST) begin
              state_d = ST_PAY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            if (up_if.sym_valid) begin
              sym_i_d = up_if.sym_in_i;
              sym_q_d = up_if.sym_in_q;
            end else if (underrun_q != 8'hFF) begin
              underrun_d = underrun_q + 8'd1;
            end
            if (cnt_q == PAY_LAST) begin
              state_d = ST_FLUSH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt_q    <= '0;
      sam_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      start_pend_q <= 1'b0;
      abort_pend_q <= 1'b0;
      sym_i_q      <= IDLE_SYM;
      sym_q_q      <= IDLE_SYM;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= '0;
    end else begin
      clk_cnt_q    <= clk_cnt_d;
      sam_cnt_q    <= sam_cnt_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_pend_q <= start_pend_d;
      abort_pend_q <= abort_pend_d;
      sym_i_q      <= sym_i_d;
      sym_q_q      <= sym_q_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer (default parameters).
// Stimulus pushes the expected per-slot output into exp_q; a monitor pops one
// entry at every symbol slot and compares sym_ready, syms_out_i/q and done.
module tb_tx_frame_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sam_clk_ena, sym_clk_ena, busy, done;
  logic [1:0] syms_out_i, syms_out_q;
  logic [7:0] underrun_cnt;

  tx_frame_sequencer_if up_if ();

  tx_frame_sequencer u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .up_if        (up_if),
    .sam_clk_ena  (sam_clk_ena),
    .sym_clk_ena  (sym_clk_ena),
    .syms_out_i   (syms_out_i),
    .syms_out_q   (syms_out_q),
    .busy         (busy),
    .done         (done),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] i;
    logic [1:0] q;
    logic       rdy;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rdy_cnt  = 0;
  int   done_cnt = 0;
  int   val_lo   = 99;
  int   val_hi   = 99;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push(input logic [1:0] i, input logic [1:0] q,
                               input logic rdy, input logic dn);
    exp_t e;
    e.i = i; e.q = q; e.rdy = rdy; e.dn = dn;
    exp_q.push_back(e);
  endfunction

  function automatic void push_pre();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) push(2'b11, 2'b11, 1'b0, 1'b0);
      else            push(2'b00, 2'b00, 1'b0, 1'b0);
    end
  endfunction

  function automatic void push_flush(input int n);
    for (int k = 0; k < n; k++) push(2'b01, 2'b01, 1'b0, (k == n - 1));
  endfunction

  function automatic void push_data(input int idx);
    push(2'(idx % 4), 2'((idx + 1) % 4), 1'b1, 1'b0);
  endfunction

  // Scoreboard monitor: one queue entry per symbol slot while entries exist.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sym_clk_ena && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("slot_ready", int'(up_if.sym_ready), int'(e.rdy));
        @(posedge clk); #1;
        chk("syms_out_i", int'(syms_out_i), int'(e.i));
        chk("syms_out_q", int'(syms_out_q), int'(e.q));
        chk("done_after_slot", int'(done), int'(e.dn));
      end else if (!sym_clk_ena) begin
        chk("ready_outside_slot", int'(up_if.sym_ready), 0);
      end
    end
  end

  // Event counters for ready pulses and done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (up_if.sym_ready) rdy_cnt++;
      if (done) done_cnt++;
    end
  end

  // Upstream source: data counts transfers, valid dropped for payload slots val_lo..val_hi.
  initial begin
    int idx;
    int ps;
    logic xf, sl;
    idx = 0; ps = 0;
    up_if.sym_valid = 1'b1;
    up_if.sym_in_i  = 2'd0;
    up_if.sym_in_q  = 2'd1;
    forever begin
      @(negedge clk);
      xf = up_if.sym_valid && up_if.sym_ready;
      sl = up_if.sym_ready;
      @(posedge clk); #1;
      if (!busy) begin
        idx = 0; ps = 0;
      end else begin
        if (xf) idx++;
        if (sl) ps++;
      end
      up_if.sym_valid = !(ps >= val_lo && ps <= val_hi);
      up_if.sym_in_i  = 2'(idx % 4);
      up_if.sym_in_q  = 2'((idx + 1) % 4);
    end
  end

  task automatic sync_slot();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sym_clk_ena && n < 40);
    if (!sym_clk_ena) chk("slot_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Strobe phase after reset release: sam on every 4th clk, sym on every 16th.
  task automatic check_strobes(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("sam_clk_ena", int'(sam_clk_ena), int'(k % 4 == 0));
      chk("sym_clk_ena", int'(sym_clk_ena), int'(k % 16 == 0));
      chk("idle_busy", int'(busy), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0;

    // 1: reset state and free-running strobes while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_syms_i", int'(syms_out_i), 1);
    chk("rst_syms_q", int'(syms_out_q), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_underrun", int'(underrun_cnt), 0);
    chk("rst_sam", int'(sam_clk_ena), 0);
    chk("rst_sym", int'(sym_clk_ena), 0);
    for (int k = 0; k < 4; k++) push(2'b01, 2'b01, 1'b0, 1'b0);
    reset = 1'b0;
    check_strobes(64);
    wait_drain("idle");

    // 2: full frame, source always valid.
    sync_slot();
    r0 = rdy_cnt; d0 = done_cnt;
    push_pre();
    for (int k = 0; k < 32; k++) push_data(k);
    push_flush(12);
    start_pulse();
    sync_slot();
    chk("frame_busy", int'(busy), 1);
    wait_drain("frame");
    chk("frame_underrun", int'(underrun_cnt), 0);
    chk("frame_ready_pulses", rdy_cnt - r0, 32);
    chk("frame_done_pulses", done_cnt - d0, 1);
    chk("frame_busy_end", int'(busy), 0);

    // 3: underrun on payload slots 3..5.
    val_lo = 3; val_hi = 5;
    sync_slot();
    r0 = rdy_cnt; d0 = done_cnt;
    push_pre();
    for (int k = 0; k < 32; k++) begin
      if (k >= 3 && k <= 5) push(2'b01, 2'b01, 1'b1, 1'b0);
      else                  push_data((k < 3) ? k : k - 3);
    end
    push_flush(12);
    start_pulse();
    wait_drain("underrun");
    chk("underrun_cnt", int'(underrun_cnt), 3);
    chk("underrun_ready_pulses", rdy_cnt - r0, 32);
    chk("underrun_done_pulses", done_cnt - d0, 1);
    val_lo = 99; val_hi = 99;

    // 4: start while busy is ignored; abort after payload slot 10.
    sync_slot();
    r0 = rdy_cnt; d0 = done_cnt;
    push_pre();
    for (int k = 0; k < 11; k++) push_data(k);
    push(2'b01, 2'b01, 1'b0, 1'b0);
    push_flush(11);
    push(2'b01, 2'b01, 1'b0, 1'b0);
    push(2'b01, 2'b01, 1'b0, 1'b0);
    start_pulse();
    repeat (3) sync_slot();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) sync_slot();
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_drain("abort");
    chk("abort_ready_pulses", rdy_cnt - r0, 11);
    chk("abort_done_pulses", done_cnt - d0, 1);
    chk("abort_busy_end", int'(busy), 0);
    chk("abort_underrun", int'(underrun_cnt), 3);

    // 5: start together with abort in IDLE is dropped.
    sync_slot();
    r0 = rdy_cnt; d0 = done_cnt;
    for (int k = 0; k < 3; k++) push(2'b01, 2'b01, 1'b0, 1'b0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    wait_drain("start_abort");
    chk("sa_busy", int'(busy), 0);
    chk("sa_ready_pulses", rdy_cnt - r0, 0);
    chk("sa_done_pulses", done_cnt - d0, 0);

    // 6: reset in the middle of the payload.
    sync_slot();
    push_pre();
    for (int k = 0; k < 5; k++) push_data(k);
    start_pulse();
    repeat (13) sync_slot();
    chk("pre_reset_busy", int'(busy), 1);
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_syms_i", int'(syms_out_i), 1);
    chk("mid_rst_syms_q", int'(syms_out_q), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_underrun", int'(underrun_cnt), 0);
    chk("mid_rst_sam", int'(sam_clk_ena), 0);
    chk("mid_rst_sym", int'(sym_clk_ena), 0);
    push(2'b01, 2'b01, 1'b0, 1'b0);
    reset = 1'b0;
    check_strobes(16);
    wait_drain("reset");
    chk("reset_done_pulses", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
